dtm_dmi_dr: RTL and testbench
=============================

Name: dtm_dmi_dr

Overview:
- DMI access data register of the RISC-V Debug Transport Module, directly downstream of the JTAG TAP controller.
- Consumes the TAP's capture/shift/update strobes, TDI and the DMI select/clear lines, and returns the serial DMI TDO bit.
- Converts each completed DR scan into a single DMI request to the Debug Module over a valid/ready handshake, then collects the response.
- Keeps the sticky DMI status reported through dtmcs.dmistat.

Parameters:
ABITS, 7, DMI address width; DR length = ABITS+34
DR_LEN, ABITS+34, derived localparam; not overridable

Ports:
TCK_i  in  1  JTAG test clock; sole clock, all state on rising edge
TRST_ni  in  1  synchronous active-low reset
TDI_i  in  1  serial data in from TAP
capture_i  in  1  TAP Capture-DR strobe
shift_i  in  1  TAP Shift-DR strobe
update_i  in  1  TAP Update-DR strobe
DMI_select_i  in  1  IR selects DMI access register
DMI_clear_i  in  1  TAP Test-Logic-Reset indication
DMI_TDO_o  out  1  serial data out (shift register LSB)
dmi_reset_i  in  1  dtmcs.dmireset pulse: clears sticky status
dmi_hard_reset_i  in  1  dtmcs.dmihardreset pulse: aborts transaction
dmi_stat_o  out  2  sticky status to dtmcs.dmistat
dmi_req_valid_o  out  1  request valid
dmi_req_ready_i  in  1  DM accepts request
dmi_req_addr_o  out  ABITS  request address
dmi_req_op_o  out  2  1=read, 2=write
dmi_req_data_o  out  32  write data
dmi_rsp_valid_i  in  1  DM response valid
dmi_rsp_ready_o  out  1  response ready
dmi_rsp_data_i  in  32  response data
dmi_rsp_resp_i  in  2  0=ok, 2=failed, 3=busy

Behaviour:
- DR layout: [DR_LEN-1:34]=address, [33:2]=data, [1:0]=op. Shifted LSB first.
- Reset (TRST_ni=0 at a rising edge), all of the following are cleared:
  - state -> IDLE.
  - shift_q, addr_q, data_q, sticky_q all 0.
  - All outputs 0: dmi_req_valid_o, dmi_rsp_ready_o, dmi_stat_o, DMI_TDO_o, and the request address, op and data.
- DMI_TDO_o = shift_q[0], combinational.
- FSM states: IDLE, REQ, RSP.
  - IDLE: on update_i & DMI_select_i with op in {1,2}, sticky_q==0 -> latch addr/data/op into request regs and addr_q; go to REQ. dmi_req_valid_o is high from the next cycle.
  - REQ: dmi_req_valid_o=1, request fields stable. On dmi_req_ready_i -> RSP.
  - RSP: dmi_rsp_ready_o=1. On dmi_rsp_valid_i:
    - data_q <= dmi_rsp_data_i.
    - If resp is 2 or 3 and sticky_q==0, sticky_q <= resp.
    - Go to IDLE.
  - dmi_rsp_valid_i outside RSP is ignored.
- Capture (capture_i & DMI_select_i): shift_q <= {addr_q, data_q, opstat}.
  - If state != IDLE: opstat=3 and sticky_q <= 3 (when sticky_q is 0).
  - Otherwise opstat = sticky_q.
- Shift (shift_i & DMI_select_i): shift_q <= {TDI_i, shift_q[DR_LEN-1:1]}.
- Update rejection cases (no request, fields unchanged):
  - Update while state != IDLE: ignored; sticky_q <= 3 if 0.
  - Update while sticky_q != 0: ignored.
  - op 0 (nop) or 3 (reserved): no request, no status change.
- dmi_stat_o = sticky_q.
- dmi_reset_i clears sticky_q. A same-cycle update is evaluated against the pre-clear value.
- dmi_hard_reset_i or DMI_clear_i:
  - State -> IDLE, sticky_q -> 0, and valid/ready drop on the next cycle.
  - Any outstanding transaction is abandoned; a late response is ignored.
  - shift_q, addr_q and data_q are kept.
- Priority: TRST_ni > (dmi_hard_reset_i | DMI_clear_i) > dmi_reset_i > FSM/strobes.
- Strobes with DMI_select_i=0 have no effect.

Test Plan:
- Write: shift addr=0x10, data=0xDEADBEEF, op=2, then update -> next cycle valid=1, addr=0x10, op=2, data=0xDEADBEEF; held 3 cycles with ready=0; drops the cycle after ready=1.
- Read: op=1, addr=0x11; DM responds data=0x12345678, resp=0 -> next capture/shift outputs op=0, data=0x12345678, addr=0x11 on TDO LSB-first.
- Busy: capture while in RSP -> captured op=3, dmi_stat_o=3. Following write update -> no valid. dmi_reset_i pulse -> stat 0; a new write is then issued.
- Failed: response resp=2 -> dmi_stat_o=2. Next capture op=2. Next update ignored.
- Hard reset in REQ (ready=0): pulse dmi_hard_reset_i -> valid 0 next cycle, stat 0. A later rsp_valid is ignored and does not change data_q.
- Sync reset: TRST_ni=0 mid-RSP -> at the next edge all outputs 0. With TRST_ni=0 and no edge, outputs are unchanged.

Source files
------------

// File: rtl/dtm_dmi_dr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : dtm_dmi_dr
//  Description : RISC-V Debug Transport Module DMI access data register.
//                Turns completed DR scans into DMI requests over a
//                valid/ready handshake, captures the response back into the
//                scan chain and keeps the sticky dmistat status.
//  Revision    : 1.0 - initial release
// ============================================================================
module dtm_dmi_dr #(
    parameter int ABITS = 7
) (
    input  logic              TCK_i,
    input  logic              TRST_ni,
    input  logic              TDI_i,
    input  logic              capture_i,
    input  logic              shift_i,
    input  logic              update_i,
    input  logic              DMI_select_i,
    input  logic              DMI_clear_i,
    output logic              DMI_TDO_o,
    input  logic              dmi_reset_i,
    input  logic              dmi_hard_reset_i,
    output logic [1:0]        dmi_stat_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [ABITS-1:0]  dmi_req_addr_o,
    output logic [1:0]        dmi_req_op_o,
    output logic [31:0]       dmi_req_data_o,
    input  logic              dmi_rsp_valid_i,
    output logic              dmi_rsp_ready_o,
    input  logic [31:0]       dmi_rsp_data_i,
    input  logic [1:0]        dmi_rsp_resp_i
);

    localparam int DR_LEN = ABITS + 34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DR_LEN-1:0]   r_shift;
    logic [ABITS-1:0]    r_addr;
    logic [31:0]         r_data;
    logic [1:0]          r_sticky;
    logic                r_req_valid;
    logic                r_rsp_ready;
    logic [ABITS-1:0]    r_req_addr;
    logic [1:0]          r_req_op;
    logic [31:0]         r_req_data;

    logic                w_capture;
    logic                w_shift;
    logic                w_update;
    logic                w_abort;
    logic                w_busy;
    logic [1:0]          w_opstat;
    logic [1:0]          w_up_op;
    logic [ABITS-1:0]    w_up_addr;
    logic [31:0]         w_up_data;
    logic                w_op_valid;
    logic                w_rsp_err;

    // TAP strobes only count while the IR selects the DMI register
    assign w_capture  = capture_i & DMI_select_i;
    assign w_shift    = shift_i   & DMI_select_i;
    assign w_update   = update_i  & DMI_select_i;
    assign w_abort    = dmi_hard_reset_i | DMI_clear_i;
    assign w_busy     = (r_state != ST_IDLE);
    // A scan that lands while a transaction is in flight reports "busy"
    assign w_opstat   = w_busy ? 2'b11 : r_sticky;
    assign w_up_op    = r_shift[1:0];
    assign w_up_data  = r_shift[33:2];
    assign w_up_addr  = r_shift[DR_LEN-1:34];
    assign w_op_valid = (w_up_op == 2'b01) || (w_up_op == 2'b10);
    // resp 2 (failed) and 3 (busy) both have bit 1 set
    assign w_rsp_err  = dmi_rsp_resp_i[1];

    assign DMI_TDO_o       = r_shift[0];
    assign dmi_stat_o      = r_sticky;
    assign dmi_req_valid_o = r_req_valid;
    assign dmi_rsp_ready_o = r_rsp_ready;
    assign dmi_req_addr_o  = r_req_addr;
    assign dmi_req_op_o    = r_req_op;
    assign dmi_req_data_o  = r_req_data;

    // Scan chain: parallel capture of {addr, data, status}, LSB-first shift
    always_ff @(posedge TCK_i) begin
        if (!TRST_ni) begin
            r_shift <= '0;
        end else if (!w_abort) begin
            if (w_capture) begin
                r_shift <= {r_addr, r_data, w_opstat};
            end else if (w_shift) begin
                r_shift <= {TDI_i, r_shift[DR_LEN-1:1]};
            end
        end
    end

    // Request/response FSM with registered handshake outputs and sticky status
    always_ff @(posedge TCK_i) begin
        if (!TRST_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_sticky    <= 2'b00;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_req_addr  <= '0;
            r_req_op    <= 2'b00;
            r_req_data  <= '0;
        end else if (w_abort) begin
            // Abandon any transaction; scan contents and request fields stay
            r_state     <= ST_IDLE;
            r_sticky    <= 2'b00;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_update && (r_sticky == 2'b00) && w_op_valid) begin
                        r_req_addr  <= w_up_addr;
                        r_req_data  <= w_up_data;
                        r_req_op    <= w_up_op;
                        r_addr      <= w_up_addr;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmi_req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (dmi_rsp_valid_i) begin
                        r_data      <= dmi_rsp_data_i;
                        r_rsp_ready <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (w_rsp_err && (r_sticky == 2'b00)) begin
                            r_sticky <= dmi_rsp_resp_i;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                    r_rsp_ready <= 1'b0;
                end
            endcase

            // Debugger touched the register mid-transaction: latch "busy"
            if ((w_update || w_capture) && w_busy && (r_sticky == 2'b00)) begin
                r_sticky <= 2'b11;
            end

            // dmireset wins over any status raised in the same cycle
            if (dmi_reset_i) begin
                r_sticky <= 2'b00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtm_dmi_dr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dtm_dmi_dr
//  Description : Self-checking bench for dtm_dmi_dr: table of transactions,
//                hand-written corner sequences and randomized traffic, all
//                compared against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dtm_dmi_dr;

    localparam int ABITS  = 7;
    localparam int DR_LEN = ABITS + 34;

    logic              TCK_i = 1'b0;
    logic              TRST_ni;
    logic              TDI_i;
    logic              capture_i;
    logic              shift_i;
    logic              update_i;
    logic              DMI_select_i;
    logic              DMI_clear_i;
    logic              DMI_TDO_o;
    logic              dmi_reset_i;
    logic              dmi_hard_reset_i;
    logic [1:0]        dmi_stat_o;
    logic              dmi_req_valid_o;
    logic              dmi_req_ready_i;
    logic [ABITS-1:0]  dmi_req_addr_o;
    logic [1:0]        dmi_req_op_o;
    logic [31:0]       dmi_req_data_o;
    logic              dmi_rsp_valid_i;
    logic              dmi_rsp_ready_o;
    logic [31:0]       dmi_rsp_data_i;
    logic [1:0]        dmi_rsp_resp_i;

    dtm_dmi_dr #(.ABITS(ABITS)) u_dut (
        .TCK_i            (TCK_i),
        .TRST_ni          (TRST_ni),
        .TDI_i            (TDI_i),
        .capture_i        (capture_i),
        .shift_i          (shift_i),
        .update_i         (update_i),
        .DMI_select_i     (DMI_select_i),
        .DMI_clear_i      (DMI_clear_i),
        .DMI_TDO_o        (DMI_TDO_o),
        .dmi_reset_i      (dmi_reset_i),
        .dmi_hard_reset_i (dmi_hard_reset_i),
        .dmi_stat_o       (dmi_stat_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_rsp_valid_i  (dmi_rsp_valid_i),
        .dmi_rsp_ready_o  (dmi_rsp_ready_o),
        .dmi_rsp_data_i   (dmi_rsp_data_i),
        .dmi_rsp_resp_i   (dmi_rsp_resp_i)
    );

    always #5 TCK_i = ~TCK_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the DR is a queue of bits (front = TDO side), the
    // transaction is tracked as "request outstanding" / "response owed".
    // ------------------------------------------------------------------
    bit                m_dr[$];
    logic [ABITS-1:0]  m_addr;
    logic [31:0]       m_data;
    logic [1:0]        m_sticky;
    bit                m_pend;
    bit                m_wait;
    logic [ABITS-1:0]  m_raddr;
    logic [1:0]        m_rop;
    logic [31:0]       m_rdata;
    bit                rnd_dm = 1'b0;

    function automatic logic [DR_LEN-1:0] dr_vec();
        logic [DR_LEN-1:0] v;
        for (int i = 0; i < DR_LEN; i++) v[i] = m_dr[i];
        return v;
    endfunction

    task automatic model_step();
        logic [1:0]        s;
        logic [1:0]        ns;
        bit                busy;
        logic [DR_LEN-1:0] v;
        logic [ABITS-1:0]  o_addr;
        logic [31:0]       o_data;
        if (!TRST_ni) begin
            m_dr.delete();
            for (int i = 0; i < DR_LEN; i++) m_dr.push_back(1'b0);
            m_addr = '0; m_data = '0; m_sticky = 2'd0; m_pend = 0; m_wait = 0;
            m_raddr = '0; m_rop = 2'd0; m_rdata = '0;
            return;
        end
        if (dmi_hard_reset_i || DMI_clear_i) begin
            m_pend = 0; m_wait = 0; m_sticky = 2'd0;
            return;
        end
        s = m_sticky; ns = s; busy = m_pend || m_wait;
        o_addr = m_addr; o_data = m_data;
        if (m_pend && dmi_req_ready_i) begin
            m_pend = 0; m_wait = 1;
        end else if (m_wait && dmi_rsp_valid_i) begin
            m_data = dmi_rsp_data_i;
            if (dmi_rsp_resp_i >= 2 && s == 2'd0) ns = dmi_rsp_resp_i;
            m_wait = 0;
        end
        if (DMI_select_i && update_i) begin
            v = dr_vec();
            if (busy) begin
                if (s == 2'd0) ns = 2'd3;
            end else if (s == 2'd0 && (v[1:0] == 2'd1 || v[1:0] == 2'd2)) begin
                m_pend  = 1;
                m_rop   = v[1:0];
                m_rdata = v[33:2];
                m_raddr = v[DR_LEN-1:34];
                m_addr  = v[DR_LEN-1:34];
            end
        end
        if (DMI_select_i && capture_i) begin
            v = {o_addr, o_data, busy ? 2'd3 : s};
            m_dr.delete();
            for (int i = 0; i < DR_LEN; i++) m_dr.push_back(v[i]);
            if (busy && s == 2'd0) ns = 2'd3;
        end else if (DMI_select_i && shift_i) begin
            void'(m_dr.pop_front());
            m_dr.push_back(TDI_i);
        end
        if (dmi_reset_i) ns = 2'd0;
        m_sticky = ns;
    endtask

    task automatic check_model();
        chk("mdl valid",    64'(dmi_req_valid_o), 64'(m_pend));
        chk("mdl rsp_ready", 64'(dmi_rsp_ready_o), 64'(m_wait));
        chk("mdl stat",     64'(dmi_stat_o),      64'(m_sticky));
        chk("mdl tdo",      64'(DMI_TDO_o),       64'(m_dr[0]));
        chk("mdl req_addr", 64'(dmi_req_addr_o),  64'(m_raddr));
        chk("mdl req_op",   64'(dmi_req_op_o),    64'(m_rop));
        chk("mdl req_data", 64'(dmi_req_data_o),  64'(m_rdata));
    endtask

    // One clock: optional random DM/control traffic, model step, edge, compare
    task automatic cycle();
        if (rnd_dm) begin
            dmi_req_ready_i  = ($urandom_range(2) == 0);
            dmi_rsp_valid_i  = ($urandom_range(2) == 0);
            dmi_rsp_data_i   = $urandom;
            dmi_rsp_resp_i   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd0;
            dmi_reset_i      = ($urandom_range(59) == 0);
            dmi_hard_reset_i = ($urandom_range(199) == 0);
            DMI_clear_i      = ($urandom_range(299) == 0);
        end
        model_step();
        @(posedge TCK_i);
        #1;
        check_model();
    endtask

    // Capture, shift the full DR (reading TDO), optionally update
    task automatic scan(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op,
                        input bit do_update, output logic [DR_LEN-1:0] cap);
        logic [DR_LEN-1:0] v;
        v = {a, d, op};
        capture_i = 1'b1; cycle(); capture_i = 1'b0;
        shift_i = 1'b1;
        for (int i = 0; i < DR_LEN; i++) begin
            cap[i] = DMI_TDO_o;
            TDI_i  = v[i];
            cycle();
        end
        shift_i = 1'b0; TDI_i = 1'b0;
        if (do_update) begin
            update_i = 1'b1; cycle(); update_i = 1'b0;
        end
    endtask

    task automatic pulse_dmi_reset();
        dmi_reset_i = 1'b1; cycle(); dmi_reset_i = 1'b0;
    endtask

    task automatic dm_accept();
        dmi_req_ready_i = 1'b1; cycle(); dmi_req_ready_i = 1'b0;
    endtask

    task automatic dm_respond(input logic [31:0] d, input logic [1:0] r);
        dmi_rsp_valid_i = 1'b1; dmi_rsp_data_i = d; dmi_rsp_resp_i = r;
        cycle();
        dmi_rsp_valid_i = 1'b0; dmi_rsp_data_i = '0; dmi_rsp_resp_i = 2'd0;
    endtask

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [31:0]      data;
        logic [1:0]       op;
        int               hold;
        logic [1:0]       resp;
        logic [31:0]      rdata;
        bit               issued;
        logic [1:0]       stat;
        logic [ABITS-1:0] cap_addr;
        logic [31:0]      cap_data;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DR_LEN-1:0] cap;

        //         addr   data          op hold resp rdata         iss stat cap_addr cap_data
        tbl[0] = '{7'h10, 32'hDEADBEEF, 2, 3,   0,   32'hCAFEF00D, 1,  0,   7'h10,   32'hCAFEF00D};
        tbl[1] = '{7'h11, 32'h00000000, 1, 1,   0,   32'h12345678, 1,  0,   7'h11,   32'h12345678};
        tbl[2] = '{7'h22, 32'h00000000, 1, 0,   2,   32'hAAAA5555, 1,  2,   7'h22,   32'hAAAA5555};
        tbl[3] = '{7'h33, 32'h01020304, 2, 2,   3,   32'h0BADF00D, 1,  3,   7'h33,   32'h0BADF00D};
        tbl[4] = '{7'h44, 32'h11111111, 0, 0,   0,   32'h00000000, 0,  0,   7'h33,   32'h0BADF00D};
        tbl[5] = '{7'h55, 32'h22222222, 3, 0,   0,   32'h00000000, 0,  0,   7'h33,   32'h0BADF00D};
        tbl[6] = '{7'h7F, 32'hFFFFFFFF, 2, 0,   1,   32'h13579BDF, 1,  0,   7'h7F,   32'h13579BDF};

        TRST_ni = 1'b0; TDI_i = 1'b0; capture_i = 1'b0; shift_i = 1'b0; update_i = 1'b0;
        DMI_select_i = 1'b1; DMI_clear_i = 1'b0; dmi_reset_i = 1'b0; dmi_hard_reset_i = 1'b0;
        dmi_req_ready_i = 1'b0; dmi_rsp_valid_i = 1'b0; dmi_rsp_data_i = '0; dmi_rsp_resp_i = 2'd0;

        // Reset state
        cycle(); cycle();
        chk("reset valid", 64'(dmi_req_valid_o), 64'd0);
        chk("reset rsp_ready", 64'(dmi_rsp_ready_o), 64'd0);
        chk("reset stat", 64'(dmi_stat_o), 64'd0);
        chk("reset tdo", 64'(DMI_TDO_o), 64'd0);
        TRST_ni = 1'b1;
        cycle();

        // Table of single transactions
        for (int k = 0; k < 7; k++) begin
            pulse_dmi_reset();
            scan(tbl[k].addr, tbl[k].data, tbl[k].op, 1'b1, cap);
            if (tbl[k].issued) begin
                chk("tbl valid", 64'(dmi_req_valid_o), 64'd1);
                chk("tbl addr", 64'(dmi_req_addr_o), 64'(tbl[k].addr));
                chk("tbl op", 64'(dmi_req_op_o), 64'(tbl[k].op));
                chk("tbl data", 64'(dmi_req_data_o), 64'(tbl[k].data));
                for (int h = 0; h < tbl[k].hold; h++) begin
                    cycle();
                    chk("tbl hold valid", 64'(dmi_req_valid_o), 64'd1);
                end
                dm_accept();
                chk("tbl valid drop", 64'(dmi_req_valid_o), 64'd0);
                chk("tbl rsp_ready", 64'(dmi_rsp_ready_o), 64'd1);
                dm_respond(tbl[k].rdata, tbl[k].resp);
                chk("tbl rsp_ready drop", 64'(dmi_rsp_ready_o), 64'd0);
            end else begin
                chk("tbl no valid", 64'(dmi_req_valid_o), 64'd0);
                cycle();
                chk("tbl no valid later", 64'(dmi_req_valid_o), 64'd0);
            end
            chk("tbl stat", 64'(dmi_stat_o), 64'(tbl[k].stat));
            scan('0, '0, 2'd0, 1'b1, cap);
            chk("tbl cap op", 64'(cap[1:0]), 64'(tbl[k].stat));
            chk("tbl cap data", 64'(cap[33:2]), 64'(tbl[k].cap_data));
            chk("tbl cap addr", 64'(cap[DR_LEN-1:34]), 64'(tbl[k].cap_addr));
        end

        // Busy: capture during RSP, rejected update, clear and retry
        pulse_dmi_reset();
        scan(7'h11, 32'h0, 2'd1, 1'b1, cap);
        chk("busy read valid", 64'(dmi_req_valid_o), 64'd1);
        dm_accept();
        scan('0, '0, 2'd0, 1'b0, cap);
        chk("busy cap op", 64'(cap[1:0]), 64'd3);
        chk("busy stat", 64'(dmi_stat_o), 64'd3);
        scan(7'h20, 32'h1111, 2'd2, 1'b1, cap);
        cycle();
        chk("busy update ignored", 64'(dmi_req_valid_o), 64'd0);
        dm_respond(32'h5A5A5A5A, 2'd0);
        chk("busy stat held", 64'(dmi_stat_o), 64'd3);
        pulse_dmi_reset();
        chk("busy stat cleared", 64'(dmi_stat_o), 64'd0);
        scan(7'h21, 32'h2222, 2'd2, 1'b1, cap);
        chk("busy retry valid", 64'(dmi_req_valid_o), 64'd1);
        chk("busy retry addr", 64'(dmi_req_addr_o), 64'h21);
        dm_accept();
        dm_respond(32'h0, 2'd0);

        // Failed response blocks the next update
        scan(7'h30, 32'h0, 2'd1, 1'b1, cap);
        dm_accept();
        dm_respond(32'h0F0F0F0F, 2'd2);
        chk("failed stat", 64'(dmi_stat_o), 64'd2);
        scan(7'h31, 32'h3333, 2'd2, 1'b1, cap);
        chk("failed cap op", 64'(cap[1:0]), 64'd2);
        chk("failed cap data", 64'(cap[33:2]), 64'h0F0F0F0F);
        chk("failed update ignored", 64'(dmi_req_valid_o), 64'd0);

        // Hard reset while the request is pending
        pulse_dmi_reset();
        scan(7'h40, 32'h4444, 2'd2, 1'b1, cap);
        chk("hard valid before", 64'(dmi_req_valid_o), 64'd1);
        dmi_hard_reset_i = 1'b1; cycle(); dmi_hard_reset_i = 1'b0;
        chk("hard valid dropped", 64'(dmi_req_valid_o), 64'd0);
        chk("hard stat", 64'(dmi_stat_o), 64'd0);
        dm_respond(32'hFFFF0000, 2'd2);
        chk("hard late rsp stat", 64'(dmi_stat_o), 64'd0);
        scan('0, '0, 2'd0, 1'b1, cap);
        chk("hard cap data kept", 64'(cap[33:2]), 64'h0F0F0F0F);
        chk("hard cap addr", 64'(cap[DR_LEN-1:34]), 64'h40);

        // Strobes with the DMI register deselected
        DMI_select_i = 1'b0;
        scan(7'h60, 32'h6, 2'd2, 1'b1, cap);
        DMI_select_i = 1'b1;
        cycle();
        chk("desel no valid", 64'(dmi_req_valid_o), 64'd0);

        // Synchronous reset in the middle of a response wait
        scan(7'h50, 32'h0, 2'd1, 1'b1, cap);
        dm_accept();
        chk("trst pre rsp_ready", 64'(dmi_rsp_ready_o), 64'd1);
        TRST_ni = 1'b0;
        #2;
        chk("trst no edge rsp_ready", 64'(dmi_rsp_ready_o), 64'd1);
        chk("trst no edge addr", 64'(dmi_req_addr_o), 64'h50);
        cycle();
        chk("trst rsp_ready", 64'(dmi_rsp_ready_o), 64'd0);
        chk("trst addr", 64'(dmi_req_addr_o), 64'd0);
        chk("trst op", 64'(dmi_req_op_o), 64'd0);
        chk("trst stat", 64'(dmi_stat_o), 64'd0);
        TRST_ni = 1'b1;
        cycle();

        // Randomized traffic against the model
        rnd_dm = 1'b1;
        for (int n = 0; n < 70; n++) begin
            DMI_select_i = ($urandom_range(7) != 0);
            scan(7'($urandom), $urandom, 2'($urandom_range(3)), ($urandom_range(5) != 0), cap);
            DMI_select_i = 1'b1;
            repeat ($urandom_range(4)) cycle();
            if ($urandom_range(24) == 0) begin
                TRST_ni = 1'b0; cycle(); TRST_ni = 1'b1;
            end
        end
        rnd_dm = 1'b0;
        dmi_req_ready_i = 1'b0; dmi_rsp_valid_i = 1'b0; dmi_reset_i = 1'b0;
        dmi_hard_reset_i = 1'b0; DMI_clear_i = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
